// File: rtl/hba_gpio_slave.sv
// hba_gpio_slave: GPIO peripheral on the HBA bus.
// Four registers (OUT, IN, INT_EN, INT_FLAGS) behind a three-state
// responder that acknowledges each selected transfer exactly once.
// gpio_in is synchronised through two flops; a third flop feeds
// rising-edge detection into the write-1-to-clear interrupt flags.
module hba_gpio_slave #(
    parameter int DBUS_WIDTH        = 8,
    parameter int PERIPH_ADDR_WIDTH = 4,
    parameter int REG_ADDR_WIDTH    = 8,
    parameter int ADDR_WIDTH        = PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH,
    parameter int PERIPH_ADDR       = 0
) (
    input  logic                  hba_clk,
    input  logic                  hba_reset_n,
    input  logic [ADDR_WIDTH-1:0] hba_abus,
    input  logic                  hba_rnw,
    input  logic                  hba_select,
    input  logic [DBUS_WIDTH-1:0] hba_dbus,
    output logic [DBUS_WIDTH-1:0] slave_dbus,
    output logic                  slave_xferack,
    output logic                  slave_interrupt,
    input  logic [DBUS_WIDTH-1:0] gpio_in,
    output logic [DBUS_WIDTH-1:0] gpio_out
);

    localparam logic [PERIPH_ADDR_WIDTH-1:0] PERIPH_SEL = PERIPH_ADDR_WIDTH'(PERIPH_ADDR);
    localparam logic [REG_ADDR_WIDTH-1:0]    REG_OUT    = REG_ADDR_WIDTH'(0);
    localparam logic [REG_ADDR_WIDTH-1:0]    REG_IN     = REG_ADDR_WIDTH'(1);
    localparam logic [REG_ADDR_WIDTH-1:0]    REG_INT_EN = REG_ADDR_WIDTH'(2);
    localparam logic [REG_ADDR_WIDTH-1:0]    REG_FLAGS  = REG_ADDR_WIDTH'(3);

    typedef enum logic [1:0] {
        IDLE          = 2'd0,
        ACK           = 2'd1,
        WAIT_DESELECT = 2'd2
    } state_t;

    state_t state_reg, state_next;

    logic [DBUS_WIDTH-1:0] out_reg, out_next;
    logic [DBUS_WIDTH-1:0] int_en_reg, int_en_next;
    logic [DBUS_WIDTH-1:0] flags_reg, flags_next;
    logic [DBUS_WIDTH-1:0] sync1_reg, sync2_reg, prev_reg;
    logic [DBUS_WIDTH-1:0] rdata_reg, rdata_next;
    logic                  irq_reg, irq_next;

    logic [REG_ADDR_WIDTH-1:0] reg_idx;
    logic                      hit;
    logic                      accept;
    logic                      wr_en;
    logic                      rd_en;
    logic [DBUS_WIDTH-1:0]     flag_clr;
    logic [DBUS_WIDTH-1:0]     rise;

    assign hit     = hba_select && (hba_abus[ADDR_WIDTH-1:REG_ADDR_WIDTH] == PERIPH_SEL);
    assign reg_idx = hba_abus[REG_ADDR_WIDTH-1:0];
    // A transfer is taken only from IDLE, so a held select never re-triggers.
    assign accept  = (state_reg == IDLE) && hit;
    assign wr_en   = accept && !hba_rnw;
    assign rd_en   = accept && hba_rnw;

    // Responder state register.
    always_ff @(posedge hba_clk or negedge hba_reset_n) begin
        if (!hba_reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Responder next-state: one ACK per selection, then wait for select to drop.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:          if (hit) state_next = ACK;
            ACK:           state_next = WAIT_DESELECT;
            WAIT_DESELECT: if (!hba_select) state_next = IDLE;
            default:       state_next = IDLE;
        endcase
    end

    // Responder outputs: acknowledge is decoded straight from the state flop.
    always_comb begin
        slave_xferack = 1'b0;
        if (state_reg == ACK) slave_xferack = 1'b1;
    end

    // Register writes and read-data capture, both at the edge entering ACK.
    always_comb begin
        out_next    = out_reg;
        int_en_next = int_en_reg;
        flag_clr    = '0;
        rdata_next  = '0;
        if (wr_en) begin
            case (reg_idx)
                REG_OUT:    out_next    = hba_dbus;
                REG_INT_EN: int_en_next = hba_dbus;
                REG_FLAGS:  flag_clr    = hba_dbus;
                default:    ;
            endcase
        end
        if (rd_en) begin
            case (reg_idx)
                REG_OUT:    rdata_next = out_reg;
                REG_IN:     rdata_next = sync2_reg;
                REG_INT_EN: rdata_next = int_en_reg;
                REG_FLAGS:  rdata_next = flags_reg;
                default:    rdata_next = '0;
            endcase
        end
    end

    // Per-bit flag update: a rising edge outranks a same-cycle clear.
    generate
        for (genvar gi = 0; gi < DBUS_WIDTH; gi++) begin : g_flag
            assign rise[gi]       = sync2_reg[gi] & ~prev_reg[gi];
            assign flags_next[gi] = rise[gi] | (flags_reg[gi] & ~flag_clr[gi]);
        end
    endgenerate

    assign irq_next = |(flags_reg & int_en_reg);

    // Datapath registers, synchroniser chain and registered interrupt.
    always_ff @(posedge hba_clk or negedge hba_reset_n) begin
        if (!hba_reset_n) begin
            out_reg    <= '0;
            int_en_reg <= '0;
            flags_reg  <= '0;
            sync1_reg  <= '0;
            sync2_reg  <= '0;
            prev_reg   <= '0;
            rdata_reg  <= '0;
            irq_reg    <= 1'b0;
        end else begin
            out_reg    <= out_next;
            int_en_reg <= int_en_next;
            flags_reg  <= flags_next;
            sync1_reg  <= gpio_in;
            sync2_reg  <= sync1_reg;
            prev_reg   <= sync2_reg;
            rdata_reg  <= rdata_next;
            irq_reg    <= irq_next;
        end
    end

    assign slave_dbus      = rdata_reg;
    assign slave_interrupt = irq_reg;
    assign gpio_out        = out_reg;

endmodule
